// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external combinational ALU between two requesters.
// Operands are registered and held for EXEC_CYCLES cycles before the result is captured.
module alu_sched #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [3:0]  r0_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [3:0]  r1_op,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] OP_UNDEF = 4'b1111;
    localparam logic [3:0] OP_PASSB = 4'b1001;

    state_t      state_reg;
    logic        last_grant_reg;
    logic        owner_reg;
    logic [3:0]  cnt_reg;
    logic [3:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_err_reg;
    logic        rsp0_valid_reg;
    logic        rsp1_valid_reg;
    logic        grant0_next;
    logic        grant1_next;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant0_next = 1'b0;
        grant1_next = 1'b0;
        if (state_reg == IDLE) begin
            if (r0_valid && (!r1_valid || last_grant_reg)) begin
                grant0_next = 1'b1;
            end else if (r1_valid) begin
                grant1_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= 4'd0;
            op_reg         <= OP_PASSB;
            a_reg          <= 32'd0;
            b_reg          <= 32'd0;
            rsp_data_reg   <= 32'd0;
            rsp_err_reg    <= 1'b0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0_next || grant1_next) begin
                        op_reg         <= grant1_next ? r1_op : r0_op;
                        a_reg          <= grant1_next ? r1_a : r0_a;
                        b_reg          <= grant1_next ? r1_b : r0_b;
                        owner_reg      <= grant1_next;
                        last_grant_reg <= grant1_next;
                        cnt_reg        <= CNT_INIT;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        rsp_err_reg    <= (op_reg == OP_UNDEF);
                        rsp_data_reg   <= (op_reg == OP_UNDEF) ? 32'd0 : alu_res;
                        rsp0_valid_reg <= !owner_reg;
                        rsp1_valid_reg <= owner_reg;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp0_valid_reg <= 1'b0;
                        rsp1_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign r0_ready   = grant0_next;
    assign r1_ready   = grant1_next;
    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_err    = rsp_err_reg;
    assign alu_op     = op_reg;
    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
endmodule

// File: tb/tb_alu_sched.sv
// Drives two alu_sched instances (EXEC_CYCLES 1 and 3) with shared stimulus and checks each
// against a transaction/timestamp model and a plain-arithmetic ALU.
module tb_alu_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid, rsp_ready;
    logic [3:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd6:  return a << b[4:0];
            4'd7:  return a >> b[4:0];
            4'd8:  return $signed(a) >>> b[4:0];
            4'd9:  return b;
            4'd10: return {31'd0, a < b};
            4'd11: return {31'd0, $signed(a) < $signed(b)};
            4'd12: return {31'd0, a == b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %08h expected %08h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                         input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        rst = rs; r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1; rsp_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int E = (gi == 0) ? 1 : 3;
        logic        r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_err;
        logic [31:0] rsp_data, alu_a, alu_b, alu_res;
        logic [3:0]  alu_op;

        alu_sched #(.EXEC_CYCLES(E)) u_dut (
            .clk(clk), .rst(rst),
            .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
            .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
            .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready),
            .rsp_data(rsp_data), .rsp_err(rsp_err),
            .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res)
        );
        assign alu_res = alu_f(alu_op, alu_a, alu_b);

        // Model: phase 0 free, 1 waiting for result, 2 response pending; timing from accept cycle.
        int          phase = 0;
        int          acc_cyc = 0;
        int          owner = 0;
        int          last_g = 1;
        logic [3:0]  m_op = 4'd9;
        logic [31:0] m_a = 0, m_b = 0, m_data = 0;
        logic        m_err = 0;

        always @(negedge clk) begin
            int g;
            g = -1;
            if (phase == 0) begin
                if (r0_valid && (!r1_valid || last_g == 1)) g = 0;
                else if (r1_valid) g = 1;
            end
            check($sformatf("E%0d r0_ready", E), r0_ready, g == 0);
            check($sformatf("E%0d r1_ready", E), r1_ready, g == 1);
            check($sformatf("E%0d rsp0_valid", E), rsp0_valid, phase == 2 && owner == 0);
            check($sformatf("E%0d rsp1_valid", E), rsp1_valid, phase == 2 && owner == 1);
            check($sformatf("E%0d rsp_data", E), rsp_data, m_data);
            check($sformatf("E%0d rsp_err", E), rsp_err, m_err);
            check($sformatf("E%0d alu_op", E), alu_op, m_op);
            check($sformatf("E%0d alu_a", E), alu_a, m_a);
            check($sformatf("E%0d alu_b", E), alu_b, m_b);
            if (rst === 1'b1) begin
                phase = 0; last_g = 1; m_op = 4'd9; m_a = 0; m_b = 0; m_data = 0; m_err = 0;
            end else if (phase == 0 && g >= 0) begin
                phase = 1; acc_cyc = cyc; owner = g; last_g = g;
                m_op = (g == 1) ? r1_op : r0_op;
                m_a  = (g == 1) ? r1_a : r0_a;
                m_b  = (g == 1) ? r1_b : r0_b;
            end else if (phase == 1 && cyc == acc_cyc + E) begin
                phase = 2;
                m_err = (m_op == 4'hF);
                m_data = m_err ? 32'd0 : alu_f(m_op, m_a, m_b);
            end else if (phase == 2 && rsp_ready) begin
                phase = 0;
                $display("E%0d txn cycle %0d r%0d op=%0d a=%08h b=%08h data=%08h err=%0d",
                         E, cyc, owner, m_op, m_a, m_b, m_data, m_err);
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Single add 5+7.
        drive(0, 1, 4'd0, 5, 7, 0, 0, 0, 0, 1);
        idle(6);
        // Held contention: subtract 10-3 from both requesters.
        for (int i = 0; i < 20; i++) drive(0, 1, 4'd1, 10, 3, 1, 4'd1, 10, 3, 1);
        idle(6);
        // Undefined opcode from r1.
        drive(0, 0, 0, 0, 0, 1, 4'hF, 1, 1, 1);
        idle(6);
        // Shift left, with r1 knocking during execution.
        drive(0, 1, 4'd6, 1, 4, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 4'd2, 32'hF0F0, 32'hFF00, 1);
        idle(6);
        // Backpressure on the response.
        drive(0, 1, 4'd4, 32'h1234_5678, 32'hFFFF_0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 4'd0, 1, 1, 1, 4'd0, 2, 2, 0);
        idle(6);
        // Reset while executing, then contention must favour r0.
        drive(0, 1, 4'd0, 3, 4, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        drive(0, 1, 4'd3, 32'hA0, 32'h0B, 1, 4'd1, 9, 4, 1);
        idle(6);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom, $urandom,
                  $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0);
        end
        idle(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
